spi_slave_core: RTL and testbench

// - SPI target (slave) engine: the far end of the SPI master's sck/nss/mosi/miso link.
// - Oversamples the external SPI pins in the system clock domain.
// - Receives words of 8/16/24/32 bits on MOSI and shifts TX words out on MISO.
// - Frame format is set by the same CPOL/CPHA/LSB/DTB fields the master uses.
// - Sits between the pad ring and an APB4 register wrapper.

---
 rtl/spi_slave_core.sv | 204 ++++++++++++++++++++
 tb/tb_spi_slave_core.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// SPI target engine: oversamples sck/nss/mosi in clk_i, shifts 8..32-bit words both ways.
// Define SPI_SLV_ERR_EN to get sticky overrun/underrun flags (ovr_o/udr_o).
module spi_slave_core #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  lsb_i,
  input  logic [1:0]            dtb_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_nss_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  busy_o,
  output logic                  ovr_o,
  output logic                  udr_o,
  input  logic                  err_clr_i
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sck_sync, nss_sync, mosi_sync;
  logic                    sck_q, nss_q;
  logic                    cpol_l, cpha_l, lsb_l;
  logic [1:0]              dtb_l;
  logic [5:0]              bitcnt, nbits, shamt;
  logic [4:0]              top;
  logic [DATA_WIDTH-1:0]   tx_sh, rx_sh, rx_next, rx_word, load_word, hold_data;
  logic                    hold_full, skip;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync  <= '0;
      nss_sync  <= '1;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
      nss_q     <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      nss_sync  <= {nss_sync[SYNC_STAGES-2:0], spi_nss_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sck_q     <= sck_sync[SYNC_STAGES-1];
      nss_q     <= nss_sync[SYNC_STAGES-1];
    end
  end

  logic sck_s, nss_s, mosi_s;
  logic nss_fall, nss_rise, lead_e, trail_e, sample_e, shift_e;
  logic word_done, abort, load_evt, tx_accept;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign nss_s    = nss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign nss_fall = nss_q & ~nss_s;
  assign nss_rise = ~nss_q & nss_s;
  assign lead_e   = (sck_q == cpol_l) & (sck_s != cpol_l);
  assign trail_e  = (sck_q != cpol_l) & (sck_s == cpol_l);
  assign sample_e = cpha_l ? trail_e : lead_e;
  assign shift_e  = cpha_l ? lead_e : trail_e;

  always_comb begin
    case (dtb_l)
      2'd0:    nbits = 6'd8;
      2'd1:    nbits = 6'd16;
      2'd2:    nbits = 6'd24;
      default: nbits = 6'd32;
    endcase
  end

  assign top       = 5'(nbits - 6'd1);
  assign shamt     = 6'(DATA_WIDTH) - nbits;
  assign rx_next   = lsb_l ? {mosi_s, rx_sh[DATA_WIDTH-1:1]} : {rx_sh[DATA_WIDTH-2:0], mosi_s};
  // LSB-first words build up from the top of the register, MSB-first from the bottom
  assign rx_word   = lsb_l ? (rx_next >> shamt) : (rx_next & ({DATA_WIDTH{1'b1}} >> shamt));
  assign load_word = hold_full ? hold_data : '0;

  assign word_done = (state == SHIFT) & sample_e & (bitcnt == nbits - 6'd1);
  assign abort     = nss_rise | ~en_i;
  assign load_evt  = ~abort & ((state == LOAD) | word_done);
  assign tx_accept = tx_valid_i & ~hold_full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cpol_l     <= 1'b0;
      cpha_l     <= 1'b0;
      lsb_l      <= 1'b0;
      dtb_l      <= 2'd0;
      bitcnt     <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      skip       <= 1'b0;
      spi_miso_o <= 1'b0;
      spi_miso_oe_o <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      hold_full  <= 1'b0;
      hold_data  <= '0;
    end else begin
      // an accept into an emptying holding reg wins over the load clearing it
      if (tx_accept) begin
        hold_full <= 1'b1;
        hold_data <= tx_data_i;
      end else if (load_evt) begin
        hold_full <= 1'b0;
      end

      if (word_done) begin
        rx_data_o  <= rx_word;
        rx_valid_o <= 1'b1;
      end else if (rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end

      if (abort) begin
        state         <= IDLE;
        bitcnt        <= '0;
        skip          <= 1'b0;
        spi_miso_o    <= 1'b0;
        spi_miso_oe_o <= 1'b0;
      end else begin
        case (state)
          IDLE: if (nss_fall) begin
            cpol_l <= cpol_i;
            cpha_l <= cpha_i;
            lsb_l  <= lsb_i;
            dtb_l  <= dtb_i;
            state  <= LOAD;
          end
          LOAD: begin
            tx_sh         <= load_word;
            spi_miso_o    <= lsb_l ? load_word[0] : load_word[top];
            spi_miso_oe_o <= 1'b1;
            skip          <= cpha_l;
            bitcnt        <= '0;
            state         <= SHIFT;
          end
          SHIFT: if (sample_e) begin
            rx_sh <= rx_next;
            if (word_done) begin
              // next word's first bit goes out now, so the coming shift edge must not advance it
              bitcnt     <= '0;
              tx_sh      <= load_word;
              spi_miso_o <= lsb_l ? load_word[0] : load_word[top];
              skip       <= 1'b1;
            end else begin
              bitcnt <= bitcnt + 6'd1;
            end
          end else if (shift_e) begin
            if (skip) begin
              skip <= 1'b0;
            end else begin
              tx_sh      <= lsb_l ? (tx_sh >> 1) : (tx_sh << 1);
              spi_miso_o <= lsb_l ? tx_sh[1] : tx_sh[5'(top - 5'd1)];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o     = (state != IDLE);
  assign tx_ready_o = ~hold_full;

`ifdef SPI_SLV_ERR_EN
  logic ovr_q, udr_q, ovr_set, udr_set;
  assign ovr_set = word_done & rx_valid_o & ~rx_ready_i;
  assign udr_set = load_evt & ~hold_full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovr_q <= 1'b0;
      udr_q <= 1'b0;
    end else begin
      if (ovr_set)        ovr_q <= 1'b1;
      else if (err_clr_i) ovr_q <= 1'b0;
      if (udr_set)        udr_q <= 1'b1;
      else if (err_clr_i) udr_q <= 1'b0;
    end
  end

  assign ovr_o = ovr_q;
  assign udr_o = udr_q;
`else
  logic unused_err;
  assign unused_err = err_clr_i;
  assign ovr_o = 1'b0;
  assign udr_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: bit-banged SPI master plus a word-level model of the TX holding reg.
module tb_spi_slave_core;

  localparam int HALF = 8;
`ifdef SPI_SLV_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b1, cpol_i = 1'b0, cpha_i = 1'b0, lsb_i = 1'b0;
  logic [1:0]  dtb_i = 2'd0;
  logic        spi_sck_i = 1'b0, spi_nss_i = 1'b1, spi_mosi_i = 1'b0;
  logic        spi_miso_o, spi_miso_oe_o;
  logic [31:0] tx_data_i = '0;
  logic        tx_valid_i = 1'b0, tx_ready_o;
  logic [31:0] rx_data_o;
  logic        rx_valid_o, rx_ready_i = 1'b0;
  logic        busy_o, ovr_o, udr_o, err_clr_i = 1'b0;

  always #5 clk_i = ~clk_i;

  spi_slave_core #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
    .lsb_i(lsb_i), .dtb_i(dtb_i), .spi_sck_i(spi_sck_i), .spi_nss_i(spi_nss_i),
    .spi_mosi_i(spi_mosi_i), .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .busy_o(busy_o), .ovr_o(ovr_o), .udr_o(udr_o), .err_clr_i(err_clr_i)
  );

  int          n_vec = 0, n_err = 0;
  logic [31:0] m_mosi [2];
  logic [31:0] m_miso [2];
  logic [31:0] got_rx [$];
  bit          rx_auto = 1'b1;
  logic        hold_full_m = 1'b0;
  logic [31:0] hold_val_m = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // consumer: take every delivered word and acknowledge it
  always @(negedge clk_i) begin
    if (rx_auto && rx_valid_o) begin
      got_rx.push_back(rx_data_o);
      rx_ready_i = 1'b1;
    end else begin
      rx_ready_i = 1'b0;
    end
  end

  function automatic logic [31:0] take_hold();
    if (hold_full_m) begin
      hold_full_m = 1'b0;
      return hold_val_m;
    end
    return '0;
  endfunction

  task automatic tx_write(input logic [31:0] w);
    @(negedge clk_i);
    chk("tx_ready_pre", tx_ready_o, 1);
    tx_data_i  = w;
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    chk("tx_ready_post", tx_ready_o, 0);
    hold_full_m = 1'b1;
    hold_val_m  = w;
  endtask

  task automatic cfg(input logic cp, input logic ch, input logic lb, input logic [1:0] dt);
    @(negedge clk_i);
    cpol_i = cp; cpha_i = ch; lsb_i = lb; dtb_i = dt;
    spi_sck_i = cp;
    repeat (6) @(negedge clk_i);
  endtask

  task automatic spi_frame(input int nwords, input int stop_at);
    int n, bi, cnt;
    bit stop;
    n = 8 * (int'(dtb_i) + 1);
    cnt = 0;
    stop = 1'b0;
    m_miso[0] = '0;
    m_miso[1] = '0;
    spi_nss_i = 1'b0;
    repeat (8) @(negedge clk_i);
    chk("miso_oe", spi_miso_oe_o, 1);
    for (int w = 0; w < nwords; w++) begin
      for (int b = 0; b < n; b++) begin
        if (cnt == stop_at) stop = 1'b1;
        if (stop) break;
        bi = lsb_i ? b : n - 1 - b;
        if (!cpha_i) begin
          spi_mosi_i = m_mosi[w][bi];
          repeat (HALF) @(negedge clk_i);
          spi_sck_i = ~cpol_i;
          m_miso[w][bi] = spi_miso_o;
          repeat (HALF) @(negedge clk_i);
          spi_sck_i = cpol_i;
        end else begin
          repeat (HALF) @(negedge clk_i);
          spi_sck_i  = ~cpol_i;
          spi_mosi_i = m_mosi[w][bi];
          repeat (HALF) @(negedge clk_i);
          spi_sck_i = cpol_i;
          m_miso[w][bi] = spi_miso_o;
        end
        cnt++;
      end
      if (stop) break;
    end
    repeat (HALF) @(negedge clk_i);
    spi_nss_i = 1'b1;
  endtask

  task automatic do_frame(input int nwords, input bit pre, input logic [31:0] pre_w,
                          input bit refill, input logic [31:0] ref_w);
    logic [31:0] exp_tx [2];
    logic [31:0] mask;
    int n;
    n = 8 * (int'(dtb_i) + 1);
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    if (pre && !hold_full_m) tx_write(pre_w);
    got_rx.delete();
    exp_tx[0] = take_hold();
    exp_tx[1] = '0;
    fork
      spi_frame(nwords, -1);
      begin
        if (refill) begin
          repeat (40) @(negedge clk_i);
          tx_write(ref_w);
        end
      end
    join
    if (nwords == 2) exp_tx[1] = take_hold();
    void'(take_hold());
    repeat (10) @(negedge clk_i);
    chk("busy_end", busy_o, 0);
    chk("rx_count", 32'(got_rx.size()), 32'(nwords));
    for (int w = 0; w < nwords; w++) begin
      chk("miso_word", m_miso[w], exp_tx[w] & mask);
      if (got_rx.size() > w) chk("rx_word", got_rx[w], m_mosi[w] & mask);
    end
  endtask

  initial begin
    logic [31:0] exp_a;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_tx_ready", tx_ready_o, 1);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_miso", {spi_miso_oe_o, spi_miso_o}, 0);
    chk("rst_rx_data", rx_data_o, 0);
    chk("rst_flags", {ovr_o, udr_o}, 0);

    // mode 0, MSB first, 8 bits
    cfg(0, 0, 0, 2'd0);
    m_mosi[0] = 32'h3C;
    do_frame(1, 1, 32'hA5, 0, '0);

    // mode 3, LSB first, 32 bits
    cfg(1, 1, 1, 2'd3);
    m_mosi[0] = 32'hDEADBEEF;
    do_frame(1, 1, 32'h12345678, 0, '0);

    // mode 1, 16 bits, two words with a refill during the first
    cfg(0, 1, 0, 2'd1);
    m_mosi[0] = $urandom;
    m_mosi[1] = $urandom;
    do_frame(2, 1, 32'h1111, 1, 32'h2222);

    // abort after 5 of 8 bits; the refilled word must survive for the next frame
    cfg(0, 0, 0, 2'd0);
    m_mosi[0] = $urandom;
    tx_write(32'h96);
    exp_a = take_hold();
    got_rx.delete();
    fork
      spi_frame(1, 5);
      begin
        repeat (40) @(negedge clk_i);
        tx_write(32'h4D);
      end
    join
    repeat (4) @(negedge clk_i);
    chk("abort_busy", busy_o, 0);
    repeat (6) @(negedge clk_i);
    chk("abort_rx_count", 32'(got_rx.size()), 0);
    chk("abort_partial", m_miso[0], exp_a & 32'hF8);
    m_mosi[0] = $urandom;
    do_frame(1, 0, '0, 0, '0);

    // empty holding reg, consumer stalled across two words
    @(negedge clk_i);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    chk("flags_cleared_pre", {ovr_o, udr_o}, 0);
    cfg(0, 0, 0, 2'd0);
    rx_auto = 1'b0;
    m_mosi[0] = 32'h5A;
    m_mosi[1] = 32'hC3;
    spi_frame(2, -1);
    repeat (3) void'(take_hold());
    repeat (10) @(negedge clk_i);
    chk("udr_miso0", m_miso[0], 0);
    chk("udr_miso1", m_miso[1], 0);
    chk("ovr_rx_valid", rx_valid_o, 1);
    chk("ovr_rx_data", rx_data_o, 32'hC3);
    chk("ovr_flag", ovr_o, ERR);
    chk("udr_flag", udr_o, ERR);
    @(negedge clk_i);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    chk("flags_cleared", {ovr_o, udr_o}, 0);
    rx_auto = 1'b1;
    repeat (3) @(negedge clk_i);
    got_rx.delete();

    // reset in the middle of a 16-bit word
    cfg(0, 0, 0, 2'd1);
    tx_write(32'h5555);
    spi_nss_i = 1'b0;
    repeat (8) @(negedge clk_i);
    repeat (3) begin
      repeat (HALF) @(negedge clk_i);
      spi_sck_i = 1'b1;
      repeat (HALF) @(negedge clk_i);
      spi_sck_i = 1'b0;
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_tx_ready", tx_ready_o, 1);
    chk("midrst_miso", {spi_miso_oe_o, spi_miso_o}, 0);
    chk("midrst_rx_valid", rx_valid_o, 0);
    repeat (2) @(negedge clk_i);
    spi_nss_i = 1'b1;
    rst_i = 1'b0;
    hold_full_m = 1'b0;
    repeat (4) @(negedge clk_i);
    m_mosi[0] = $urandom;
    do_frame(1, 1, 32'hBEEF, 0, '0);

    // randomized frames
    for (int i = 0; i < 12; i++) begin
      int nw;
      bit pre, refill;
      cfg(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      nw = $urandom_range(1, 2);
      pre = 1'($urandom);
      refill = (nw == 2) && 1'($urandom);
      m_mosi[0] = $urandom;
      m_mosi[1] = $urandom;
      do_frame(nw, pre, $urandom, refill, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
